// File: rtl/gc_analog_mapper.sv
// gc_analog_mapper
// GameCube-to-N64 analog conversion stage. Captures the neutral stick
// position on a calibration frame. Then converts every polled frame into
// signed N64 stick values (centered, deadzoned, scaled, clamped) and
// C-button bits with hysteresis. Uses a three-stage pipeline.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid                        one-cycle strobe, axis inputs hold a poll
//   stick_x, stick_y                main-stick raw axes (unsigned, IN_W)
//   cstick_x, cstick_y              C-stick raw axes (unsigned, IN_W)
//   recal_req                       one-cycle request to re-enter calibration
//   out_x, out_y                    signed N64 stick values (OUT_W)
//   c_left, c_right, c_up, c_down   C-button states
//   out_word                        {c_down, c_up, c_left, c_right, out_x, out_y}
//   out_valid                       one-cycle strobe, outputs updated
//   cal_done                        centers captured since reset / recal
module gc_analog_mapper #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int SCALE_NUM   = 25,
    parameter int SCALE_SHIFT = 5,
    parameter int DEADZONE    = 2,
    parameter int LIMIT       = 100,
    parameter int C_ON        = 72,
    parameter int C_OFF       = 56,
    parameter int CAL_WIN     = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      stick_x,
    input  logic [IN_W-1:0]      stick_y,
    input  logic [IN_W-1:0]      cstick_x,
    input  logic [IN_W-1:0]      cstick_y,
    input  logic                 recal_req,
    output logic [OUT_W-1:0]     out_x,
    output logic [OUT_W-1:0]     out_y,
    output logic                 c_left,
    output logic                 c_right,
    output logic                 c_up,
    output logic                 c_down,
    output logic [2*OUT_W+3:0]   out_word,
    output logic                 out_valid,
    output logic                 cal_done
);

    // Product width leaves room for any 16-bit scale numerator.
    localparam int PROD_W = IN_W + 1 + 16;

    localparam logic [IN_W-1:0]          MID    = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [IN_W:0]     MID_S  = $signed({1'b0, MID});
    localparam logic signed [IN_W:0]     WIN_S  = (IN_W+1)'(CAL_WIN);
    localparam logic signed [IN_W:0]     DZ_S   = (IN_W+1)'(DEADZONE);
    localparam logic signed [IN_W:0]     CON_S  = (IN_W+1)'(C_ON);
    localparam logic signed [IN_W:0]     COFF_S = (IN_W+1)'(C_OFF);
    localparam logic signed [PROD_W-1:0] SCL_S  = PROD_W'(SCALE_NUM);
    localparam logic signed [PROD_W-1:0] LIM_S  = PROD_W'(LIMIT);

    typedef enum logic [0:0] {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Signed deviation of a raw axis from a center.
    function automatic logic signed [IN_W:0] dev(input logic [IN_W-1:0] raw,
                                                 input logic [IN_W-1:0] ctr);
        return $signed({1'b0, raw}) - $signed({1'b0, ctr});
    endfunction

    // Raw axis close enough to the nominal midpoint to be a calibration sample.
    function automatic logic in_win(input logic [IN_W-1:0] raw);
        logic signed [IN_W:0] d;
        d = $signed({1'b0, raw}) - MID_S;
        return (d <= WIN_S) && (d >= -WIN_S);
    endfunction

    // Small main-stick deviations snap to zero.
    function automatic logic signed [IN_W:0] dead(input logic signed [IN_W:0] d);
        if ((d <= DZ_S) && (d >= -DZ_S)) begin
            return '0;
        end else begin
            return d;
        end
    endfunction

    // Gain stage; arithmetic shift floors toward minus infinity.
    function automatic logic signed [PROD_W-1:0] scale(input logic signed [IN_W:0] d);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(d) * SCL_S;
        return prod >>> SCALE_SHIFT;
    endfunction

    // Saturate to +/-LIMIT, then keep the low OUT_W bits.
    function automatic logic [OUT_W-1:0] clamp(input logic signed [PROD_W-1:0] v);
        if (v > LIM_S) begin
            return OUT_W'(LIM_S);
        end else if (v < -LIM_S) begin
            return OUT_W'(-LIM_S);
        end else begin
            return OUT_W'(v);
        end
    endfunction

    // C-button pair {negative side, positive side} with hysteresis.
    // Pressing one side releases the other; release needs |d| < C_OFF.
    function automatic logic [1:0] hyst(input logic signed [IN_W:0] d,
                                        input logic [1:0] cur);
        if (d >= CON_S) begin
            return 2'b01;
        end else if (d <= -CON_S) begin
            return 2'b10;
        end else if ((d < COFF_S) && (d > -COFF_S)) begin
            return 2'b00;
        end else begin
            return cur;
        end
    endfunction

    state_t          state_r, state_s;
    logic            cal_done_r, cal_done_s;
    logic            capture_s;
    logic [IN_W-1:0] ctr_sx_r, ctr_sy_r, ctr_cx_r, ctr_cy_r;
    logic [IN_W-1:0] ctr_sx_s, ctr_sy_s, ctr_cx_s, ctr_cy_s;

    logic                 s1_valid_r;
    logic signed [IN_W:0] s1_dx_r, s1_dy_r, s1_cx_r, s1_cy_r;

    logic                     s2_valid_r;
    logic signed [PROD_W-1:0] s2_x_r, s2_y_r;
    logic signed [IN_W:0]     s2_cx_r, s2_cy_r;

    logic [OUT_W-1:0] out_x_r, out_y_r;
    logic             c_left_r, c_right_r, c_up_r, c_down_r;
    logic             out_valid_r;
    logic [1:0]       hx_s, hy_s;

    // Calibration decision, next state and the centers this frame uses.
    // A recal request is honoured before judging a same-cycle frame.
    always_comb begin
        capture_s  = in_valid && ((state_r == ST_CAL) || recal_req) &&
                     in_win(stick_x) && in_win(stick_y) &&
                     in_win(cstick_x) && in_win(cstick_y);
        state_s    = state_r;
        cal_done_s = cal_done_r;
        case (state_r)
            ST_CAL: begin
                if (capture_s) begin
                    state_s    = ST_RUN;
                    cal_done_s = 1'b1;
                end else begin
                    state_s    = ST_CAL;
                    cal_done_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (recal_req && !capture_s) begin
                    state_s    = ST_CAL;
                    cal_done_s = 1'b0;
                end else begin
                    state_s    = ST_RUN;
                    cal_done_s = 1'b1;
                end
            end
            default: begin
                state_s    = ST_CAL;
                cal_done_s = 1'b0;
            end
        endcase
        if (capture_s) begin
            ctr_sx_s = stick_x;
            ctr_sy_s = stick_y;
            ctr_cx_s = cstick_x;
            ctr_cy_s = cstick_y;
        end else begin
            ctr_sx_s = ctr_sx_r;
            ctr_sy_s = ctr_sy_r;
            ctr_cx_s = ctr_cx_r;
            ctr_cy_s = ctr_cy_r;
        end
    end

    // State, calibration flag and center registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_CAL;
            cal_done_r <= 1'b0;
            ctr_sx_r   <= MID;
            ctr_sy_r   <= MID;
            ctr_cx_r   <= MID;
            ctr_cy_r   <= MID;
        end else begin
            state_r    <= state_s;
            cal_done_r <= cal_done_s;
            ctr_sx_r   <= ctr_sx_s;
            ctr_sy_r   <= ctr_sy_s;
            ctr_cx_r   <= ctr_cx_s;
            ctr_cy_r   <= ctr_cy_s;
        end
    end

    // Stage 1: center deviations, deadzone on the main stick only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_dx_r    <= '0;
            s1_dy_r    <= '0;
            s1_cx_r    <= '0;
            s1_cy_r    <= '0;
        end else begin
            s1_valid_r <= in_valid;
            s1_dx_r    <= dead(dev(stick_x, ctr_sx_s));
            s1_dy_r    <= dead(dev(stick_y, ctr_sy_s));
            s1_cx_r    <= dev(cstick_x, ctr_cx_s);
            s1_cy_r    <= dev(cstick_y, ctr_cy_s);
        end
    end

    // Stage 2: gain; C-stick deviations ride along unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_x_r     <= '0;
            s2_y_r     <= '0;
            s2_cx_r    <= '0;
            s2_cy_r    <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_x_r     <= scale(s1_dx_r);
            s2_y_r     <= scale(s1_dy_r);
            s2_cx_r    <= s1_cx_r;
            s2_cy_r    <= s1_cy_r;
        end
    end

    // Next C-button pairs from the current state and the stage-2 deviation.
    always_comb begin
        hx_s = hyst(s2_cx_r, {c_left_r, c_right_r});
        hy_s = hyst(s2_cy_r, {c_up_r, c_down_r});
    end

    // Stage 3: clamp and register outputs; values hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            c_left_r    <= 1'b0;
            c_right_r   <= 1'b0;
            c_up_r      <= 1'b0;
            c_down_r    <= 1'b0;
        end else begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_x_r   <= clamp(s2_x_r);
                out_y_r   <= clamp(s2_y_r);
                c_left_r  <= hx_s[1];
                c_right_r <= hx_s[0];
                c_up_r    <= hy_s[1];
                c_down_r  <= hy_s[0];
            end else begin
                out_x_r   <= out_x_r;
                out_y_r   <= out_y_r;
                c_left_r  <= c_left_r;
                c_right_r <= c_right_r;
                c_up_r    <= c_up_r;
                c_down_r  <= c_down_r;
            end
        end
    end

    assign out_x     = out_x_r;
    assign out_y     = out_y_r;
    assign c_left    = c_left_r;
    assign c_right   = c_right_r;
    assign c_up      = c_up_r;
    assign c_down    = c_down_r;
    assign out_valid = out_valid_r;
    assign cal_done  = cal_done_r;
    assign out_word  = {c_down_r, c_up_r, c_left_r, c_right_r, out_x_r, out_y_r};

endmodule

// File: tb/tb_gc_analog_mapper.sv
// Directed bench for gc_analog_mapper: a default instance plus a LIMIT=80
// instance driven by the same inputs. The bench samples outputs on the falling edge.
module tb_gc_analog_mapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  stick_x, stick_y, cstick_x, cstick_y;
    logic        recal_req;
    logic [7:0]  out_x, out_y;
    logic        c_left, c_right, c_up, c_down;
    logic [19:0] out_word;
    logic        out_valid, cal_done;

    logic [7:0]  l_out_x, l_out_y;
    logic        l_c_left, l_c_right, l_c_up, l_c_down;
    logic [19:0] l_out_word;
    logic        l_out_valid, l_cal_done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gc_analog_mapper dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .stick_x(stick_x), .stick_y(stick_y),
        .cstick_x(cstick_x), .cstick_y(cstick_y),
        .recal_req(recal_req),
        .out_x(out_x), .out_y(out_y),
        .c_left(c_left), .c_right(c_right), .c_up(c_up), .c_down(c_down),
        .out_word(out_word), .out_valid(out_valid), .cal_done(cal_done)
    );

    gc_analog_mapper #(.LIMIT(80)) dut_lim (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .stick_x(stick_x), .stick_y(stick_y),
        .cstick_x(cstick_x), .cstick_y(cstick_y),
        .recal_req(recal_req),
        .out_x(l_out_x), .out_y(l_out_y),
        .c_left(l_c_left), .c_right(l_c_right), .c_up(l_c_up), .c_down(l_c_down),
        .out_word(l_out_word), .out_valid(l_out_valid), .cal_done(l_cal_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame, then return on the falling edge where its outputs appear.
    task automatic frame(input logic [7:0] sx, input logic [7:0] sy,
                         input logic [7:0] cx, input logic [7:0] cy,
                         input logic rq);
        @(negedge clk);
        stick_x = sx; stick_y = sy; cstick_x = cx; cstick_y = cy;
        recal_req = rq; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; recal_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] bx[4];
        logic [7:0] ex[4];
        bx = '{8'd255, 8'd0, 8'd130, 8'd200};
        ex = '{8'h63, 8'h9C, 8'h00, 8'h38};

        rst_n = 1'b0; in_valid = 1'b0; recal_req = 1'b0;
        stick_x = 8'd128; stick_y = 8'd128; cstick_x = 8'd128; cstick_y = 8'd128;
        #1;
        chk("rst out_x", 32'(out_x), 32'h0);
        chk("rst out_y", 32'(out_y), 32'h0);
        chk("rst out_word", 32'(out_word), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst cal_done", 32'(cal_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Rejected calibration: still centered at 128.
        frame(8'd200, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("rej out_valid", 32'(out_valid), 32'h1);
        chk("rej out_x", 32'(out_x), 32'h38);
        chk("rej cal_done", 32'(cal_done), 32'h0);
        @(negedge clk);
        chk("rej pulse end", 32'(out_valid), 32'h0);

        // Capture at 128.
        frame(8'd128, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("cap out_valid", 32'(out_valid), 32'h1);
        chk("cap out_word", 32'(out_word), 32'h0);
        chk("cap cal_done", 32'(cal_done), 32'h1);
        @(negedge clk);
        chk("cap pulse end", 32'(out_valid), 32'h0);

        frame(8'd255, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("x255 out_x", 32'(out_x), 32'h63);
        chk("x255 out_word", 32'(out_word), 32'h06300);
        chk("x255 lim out_x", 32'(l_out_x), 32'h50);

        frame(8'd0, 8'd0, 8'd128, 8'd128, 1'b0);
        chk("x0 out_x", 32'(out_x), 32'h9C);
        chk("y0 out_y", 32'(out_y), 32'h9C);
        chk("x0 lim out_x", 32'(l_out_x), 32'hB0);

        frame(8'd130, 8'd126, 8'd128, 8'd128, 1'b0);
        chk("dz out_x", 32'(out_x), 32'h0);
        chk("dz out_y", 32'(out_y), 32'h0);

        // Four back-to-back frames; frame k emerges three cycles after it.
        stick_y = 8'd128;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 4) begin
                stick_x = bx[k];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (k >= 3) begin
                chk("b2b out_valid", 32'(out_valid), 32'h1);
                chk("b2b out_x", 32'(out_x), 32'(ex[k-3]));
            end
        end
        @(negedge clk);
        chk("b2b pulse end", 32'(out_valid), 32'h0);

        // C-button hysteresis.
        frame(8'd128, 8'd128, 8'd200, 8'd128, 1'b0);
        chk("c200 right", 32'(c_right), 32'h1);
        chk("c200 left", 32'(c_left), 32'h0);
        frame(8'd128, 8'd128, 8'd190, 8'd128, 1'b0);
        chk("c190 right hold", 32'(c_right), 32'h1);
        frame(8'd128, 8'd128, 8'd180, 8'd128, 1'b0);
        chk("c180 right clr", 32'(c_right), 32'h0);
        frame(8'd128, 8'd128, 8'd50, 8'd128, 1'b0);
        chk("c50 left", 32'(c_left), 32'h1);
        chk("c50 right", 32'(c_right), 32'h0);
        frame(8'd128, 8'd128, 8'd128, 8'd50, 1'b0);
        chk("cy50 up", 32'(c_up), 32'h1);
        chk("cy50 out_word", 32'(out_word), 32'h40000);

        // Recal request alone: state change only.
        @(negedge clk);
        recal_req = 1'b1;
        @(negedge clk);
        recal_req = 1'b0;
        chk("recal cal_done", 32'(cal_done), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("recal no out_valid", 32'(out_valid), 32'h0);
        end

        // Calibrate at x = 140.
        frame(8'd140, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("cal140 out_valid", 32'(out_valid), 32'h1);
        chk("cal140 out_x", 32'(out_x), 32'h0);
        chk("cal140 cal_done", 32'(cal_done), 32'h1);
        frame(8'd20, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("x20 floor out_x", 32'(out_x), 32'hA2);
        frame(8'd255, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("c140 x255 out_x", 32'(out_x), 32'h59);
        chk("c140 x255 lim", 32'(l_out_x), 32'h50);
        frame(8'd140, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("c140 x140 out_x", 32'(out_x), 32'h0);

        // Recal with a same-cycle frame: that frame becomes the new center.
        frame(8'd128, 8'd128, 8'd128, 8'd128, 1'b1);
        chk("recal+frame out_x", 32'(out_x), 32'h0);
        chk("recal+frame cal_done", 32'(cal_done), 32'h1);
        frame(8'd255, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("recentered out_x", 32'(out_x), 32'h63);

        // Reset one cycle after a frame: nothing emerges.
        @(negedge clk);
        stick_x = 8'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst no out_valid", 32'(out_valid), 32'h0);
        end
        chk("midrst out_word", 32'(out_word), 32'h0);
        chk("midrst cal_done", 32'(cal_done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst no out_valid", 32'(out_valid), 32'h0);
        frame(8'd200, 8'd128, 8'd128, 8'd128, 1'b0);
        chk("post rst out_x", 32'(out_x), 32'h38);
        chk("post rst cal_done", 32'(cal_done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
